// File: rtl/nes_pad_responder_if.sv
// Host-side NES pad bus: parallel buttons in, 4021-style latch/pulse/data serial link.
interface nes_pad_responder_if;
    logic [7:0] buttons;
    logic       nes_latch;
    logic       nes_pulse;
    logic       nes_data;
    logic [3:0] bit_count;
    logic       frame_done;

    modport master (
        output buttons,
        output nes_latch,
        output nes_pulse,
        input  nes_data,
        input  bit_count,
        input  frame_done
    );

    modport slave (
        input  buttons,
        input  nes_latch,
        input  nes_pulse,
        output nes_data,
        output bit_count,
        output frame_done
    );
endinterface

// File: rtl/nes_pad_responder.sv
// 4021-style NES pad emulator: parallel-loads ~buttons while latch is high and
// shifts one bit out per host pulse rising edge on an active-low data line.
module nes_pad_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        FILL_LEVEL  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    nes_pad_responder_if.slave   pad
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("nes_pad_responder: SYNC_STAGES must be 2 or 3");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_W-1:0]       sr_q, sr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_q, done_d;

    logic [SYNC_STAGES-1:0]  latch_sync_q, latch_sync_d;
    logic [SYNC_STAGES-1:0]  pulse_sync_q, pulse_sync_d;
    logic                    latch_prev_q, pulse_prev_q;

    logic                    latch_s, pulse_s;
    logic                    latch_fall, pulse_rise;

    // Host inputs are asynchronous; edges are taken against one extra registered copy.
    assign latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], pad.nes_latch};
    assign pulse_sync_d = {pulse_sync_q[SYNC_STAGES-2:0], pad.nes_pulse};
    assign latch_s      = latch_sync_q[SYNC_STAGES-1];
    assign pulse_s      = pulse_sync_q[SYNC_STAGES-1];
    assign latch_fall   = ~latch_s & latch_prev_q;
    assign pulse_rise   = pulse_s & ~pulse_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_sync_q <= '0;
            pulse_sync_q <= '0;
            latch_prev_q <= 1'b0;
            pulse_prev_q <= 1'b0;
        end else begin
            latch_sync_q <= latch_sync_d;
            pulse_sync_q <= pulse_sync_d;
            latch_prev_q <= latch_s;
            pulse_prev_q <= pulse_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '1;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Latch has priority over pulse; a latch in SHIFT abandons the frame silently.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (latch_s) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sr_d  = ~pad.buttons;
                cnt_d = '0;
                if (latch_fall) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (latch_s) begin
                    state_d = ST_LOAD;
                end else if (pulse_rise) begin
                    sr_d = {sr_q[DATA_W-2:0], FILL_LEVEL};
                    if (cnt_q < CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == CNT_LAST) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pad.nes_data   = sr_q[DATA_W-1];
    assign pad.bit_count  = cnt_q;
    assign pad.frame_done = done_q;

endmodule

// File: doc/nes_pad_responder.md
Name: nes_pad_responder

Overview:
- Controller-side end of the NES serial pad protocol. The Input_Controller is the console-side initiator; this block is the 4021-style responder.
- Captures an 8-bit button vector on latch and shifts it out one bit per host clock pulse on an active-low data line.
- Used as a bench/board pad emulator so Tetris can be driven without a physical controller, and as a loopback target for Input_Controller.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each asynchronous host input (nes_latch, nes_pulse); legal values are 2 or 3.
- FILL_LEVEL, 1'b0, level driven on nes_data once all 8 bits have been shifted out (the 4021 serial input is tied to ground).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- buttons  in  8  button state, active-high pressed; bit7=A, bit6=B, bit5=Select, bit4=Start, bit3=Up, bit2=Down, bit1=Left, bit0=Right.
- nes_latch  in  1  host latch; asynchronous to clk.
- nes_pulse  in  1  host shift clock; asynchronous to clk.
- nes_data  out  1  serial data to host, active-low (0 = pressed).
- bit_count  out  4  number of bits shifted since the last latch, range 0..8.
- frame_done  out  1  one-cycle strobe when the 8th bit has been shifted out.

Behaviour:
- Reset (asynchronous):
  - Shift register = 8'hFF, so nes_data = 1 (nothing pressed).
  - bit_count = 0; frame_done = 0; synchronizers and edge-detect registers = 0; state = IDLE.
- Synchronization:
  - nes_latch and nes_pulse each pass through SYNC_STAGES flops.
  - Edges are detected against one further registered copy.
  - Host high and low phases must each be at least SYNC_STAGES+2 clk cycles; shorter pulses are not guaranteed to be seen.
- State machine (3 states):
  - IDLE: shift register holds its value. Synced latch high -> LOAD.
  - LOAD: every cycle, shift register <= ~buttons (continuous parallel load, as the 4021 does) and bit_count = 0. nes_data therefore shows ~buttons[7] (A). Pulse edges are ignored. Synced latch falling edge -> SHIFT, with the last loaded value retained.
  - SHIFT: on each synced nes_pulse rising edge, shift register <= {sr[6:0], FILL_LEVEL} and bit_count <= min(bit_count+1, 8). nes_data always equals sr[7].
    - When bit_count goes from 7 to 8, frame_done = 1 for exactly one cycle.
    - Further pulses keep shifting in FILL_LEVEL; bit_count saturates at 8 and frame_done does not re-fire.
    - Synced latch high -> LOAD, which abandons the current frame with no frame_done.
- Latency:
  - nes_data changes SYNC_STAGES+1 clk cycles after the pin-level nes_pulse rise.
  - After a latch rise, the new A bit appears SYNC_STAGES+2 cycles later.
- Simultaneous latch-rise and pulse-rise in the same cycle: latch wins; no shift, LOAD entered.
- buttons changing while in SHIFT has no effect until the next latch.
- Reset asserted mid-frame: immediate return to reset values. The first latch after reset release behaves normally.
- Only rising edges of nes_pulse act; falling edges are no-ops.

Test Plan:
- Reset: reset high, buttons=8'hA5 -> nes_data=1, bit_count=0, frame_done=0. Release reset with no latch -> outputs unchanged for 100 cycles.
- Full frame: buttons=8'b1000_0001 (A + Right), latch 12 cycles, then 8 pulses of 6 cycles high/6 low.
  - During latch, after the fall, nes_data=0 (A pressed).
  - After pulses 1..6, nes_data=1.
  - After pulse 7, nes_data=0 (Right).
  - After pulse 8, nes_data=FILL_LEVEL=0, bit_count=8, one frame_done strobe.
- Overrun: 4 extra pulses after a full frame -> nes_data stays FILL_LEVEL, bit_count stays 8, no further frame_done.
- Abort: latch again after 3 pulses with buttons=8'h10 (Start) -> bit_count=0, no frame_done. The subsequent frame reads 1,1,1,0,1,1,1,1 on nes_data.
- Collision and hold: nes_pulse and nes_latch rise at the same edge -> no shift, nes_data=~buttons[7]. Change buttons from 8'h00 to 8'hFF mid-SHIFT -> remaining bits still reflect 8'h00 (all 1).
- Mid-frame reset: reset pulsed after pulse 4 -> nes_data=1 and bit_count=0 immediately (asynchronous). The next latch/8-pulse frame with buttons=8'h5A reads 1,0,1,0,0,1,0,1.
